// File: rtl/hpi_slave_port.sv
// HPI host slave: synchronized strobes, 16-bit register window onto local RAM and mailboxes.
// Host accesses take effect one cycle after start detect; reads drive the bus from T+2 until release.
module hpi_slave_port #(
  parameter int MEM_AW = 8
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic [1:0]        OTG_ADDR,
  input  logic              OTG_RD_N,
  input  logic              OTG_WR_N,
  input  logic              OTG_CS_N,
  inout  wire  [15:0]       OTG_DATA,
  output logic              OTG_INT,
  output logic [15:0]       mbx_in_data,
  output logic              mbx_in_valid,
  input  logic              mbx_in_ack,
  input  logic [15:0]       mbx_out_data,
  input  logic              mbx_out_wr,
  output logic              mbx_out_busy,
  input  logic [MEM_AW-1:0] loc_addr,
  output logic [15:0]       loc_rdata
);

  typedef enum logic [1:0] {IDLE, RD_DRIVE, WAIT_RELEASE} state_t;

  localparam logic [1:0] A_DATA    = 2'b00;
  localparam logic [1:0] A_MAILBOX = 2'b01;
  localparam logic [1:0] A_ADDRESS = 2'b10;
  localparam logic [1:0] A_STATUS  = 2'b11;

  state_t      state_q, state_d;
  logic [2:0]  rd_sync_q, wr_sync_q;
  logic [1:0]  cs_sync_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic        pend_rd_q, pend_wr_q, err_q;
  logic [15:0] ptr_q;
  logic [15:0] rdata_q;
  logic [15:0] in_data_q, in_data_d;
  logic        in_vld_q, in_vld_d;
  logic        ovr_q, ovr_d;
  logic        perr_q, perr_d;
  logic [15:0] out_q, out_d;
  logic        full_q, full_d;
  logic [15:0] loc_rdata_q;
  logic [15:0] mem [2**MEM_AW];

  logic rd_s, wr_s, cs_s, rd_fall, wr_fall;
  logic start, start_rd, start_wr, start_err;
  logic rd_exit, wr_exit, bus_oe, mbx_rd_done;
  logic host_mbx_wr, host_sts_wr;
  logic [MEM_AW-1:0] mem_idx;
  logic [15:0] status_w;

  // [1] is the synchronized level, [2] its previous value for edge detection
  assign rd_s    = rd_sync_q[1];
  assign wr_s    = wr_sync_q[1];
  assign cs_s    = cs_sync_q[1];
  assign rd_fall = rd_sync_q[2] & ~rd_sync_q[1];
  assign wr_fall = wr_sync_q[2] & ~wr_sync_q[1];

  assign start     = (state_q == IDLE) && !cs_s && (rd_fall || wr_fall);
  assign start_err = start && !rd_s && !wr_s;
  assign start_rd  = start && !rd_s && wr_s;
  assign start_wr  = start && rd_s && !wr_s;

  assign rd_exit = !pend_rd_q && (rd_s || cs_s);
  assign wr_exit = !pend_wr_q && wr_s && (!err_q || rd_s);

  assign mem_idx     = ptr_q[MEM_AW:1];
  assign status_w    = {12'h000, perr_q, ovr_q, in_vld_q, full_q};
  assign host_mbx_wr = pend_wr_q && (addr_q == A_MAILBOX);
  assign host_sts_wr = pend_wr_q && (addr_q == A_STATUS);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_rd)                   state_d = RD_DRIVE;
        else if (start_wr || start_err) state_d = WAIT_RELEASE;
      end
      RD_DRIVE:     if (rd_exit) state_d = IDLE;
      WAIT_RELEASE: if (wr_exit) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_oe      = 1'b0;
    mbx_rd_done = 1'b0;
    if (state_q == RD_DRIVE) begin
      bus_oe      = !pend_rd_q;
      mbx_rd_done = rd_exit && (addr_q == A_MAILBOX);
    end
  end

  assign OTG_DATA = bus_oe ? rdata_q : 16'hzzzz;

  // Mailbox and status next-state; an ack coincident with a host write is absorbed by the write
  always_comb begin
    in_data_d = in_data_q;
    in_vld_d  = in_vld_q;
    ovr_d     = ovr_q;
    perr_d    = perr_q;
    out_d     = out_q;
    full_d    = full_q;
    if (host_mbx_wr) begin
      in_data_d = wdata_q;
      in_vld_d  = 1'b1;
      if (in_vld_q && !mbx_in_ack) ovr_d = 1'b1;
    end else if (mbx_in_ack) begin
      in_vld_d = 1'b0;
    end
    if (host_sts_wr && wdata_q[2]) ovr_d = 1'b0;
    if (host_sts_wr && wdata_q[3]) perr_d = 1'b0;
    if (start_err) perr_d = 1'b1;
    if (mbx_rd_done) full_d = 1'b0;
    if (mbx_out_wr && (!full_q || mbx_rd_done)) begin
      out_d  = mbx_out_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      rd_sync_q <= 3'b111;
      wr_sync_q <= 3'b111;
      cs_sync_q <= 2'b11;
      addr_q    <= 2'b00;
      wdata_q   <= 16'h0000;
      pend_rd_q <= 1'b0;
      pend_wr_q <= 1'b0;
      err_q     <= 1'b0;
      ptr_q     <= 16'h0000;
      rdata_q   <= 16'h0000;
      in_data_q <= 16'h0000;
      in_vld_q  <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      out_q     <= 16'h0000;
      full_q    <= 1'b0;
    end else begin
      rd_sync_q <= {rd_sync_q[1:0], OTG_RD_N};
      wr_sync_q <= {wr_sync_q[1:0], OTG_WR_N};
      cs_sync_q <= {cs_sync_q[0], OTG_CS_N};
      pend_rd_q <= start_rd;
      pend_wr_q <= start_wr;
      if (start) begin
        addr_q  <= OTG_ADDR;
        wdata_q <= OTG_DATA;
        err_q   <= start_err;
      end
      if (pend_rd_q) begin
        unique case (addr_q)
          A_DATA: begin
            rdata_q <= mem[mem_idx];
            ptr_q   <= ptr_q + 16'd2;
          end
          A_MAILBOX: rdata_q <= out_q;
          A_ADDRESS: rdata_q <= ptr_q;
          default:   rdata_q <= status_w;
        endcase
      end
      if (pend_wr_q && (addr_q == A_ADDRESS)) ptr_q <= wdata_q;
      if (pend_wr_q && (addr_q == A_DATA))    ptr_q <= ptr_q + 16'd2;
      in_data_q <= in_data_d;
      in_vld_q  <= in_vld_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
      out_q     <= out_d;
      full_q    <= full_d;
    end
  end

  // RAM is deliberately not reset
  always_ff @(posedge Clk) begin
    if (pend_wr_q && (addr_q == A_DATA)) mem[mem_idx] <= wdata_q;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) loc_rdata_q <= 16'h0000;
    else          loc_rdata_q <= mem[loc_addr];
  end

  assign loc_rdata    = loc_rdata_q;
  assign mbx_in_data  = in_data_q;
  assign mbx_in_valid = in_vld_q;
  assign mbx_out_busy = full_q;
  assign OTG_INT      = full_q;

endmodule

// File: tb/tb_hpi_slave_port.sv
// Directed bench for hpi_slave_port; the bus carries pull-ups so an undriven bus reads 0xFFFF.
module tb_hpi_slave_port;

  localparam int AW = 7;
  localparam logic [1:0] A_DATA = 2'b00, A_MBX = 2'b01, A_ADDR = 2'b10, A_STS = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    otg_addr;
  logic          rd_n, wr_n, cs_n;
  wire  [15:0]   otg_data;
  logic          otg_int;
  logic [15:0]   mbx_in_data;
  logic          mbx_in_valid;
  logic          mbx_in_ack;
  logic [15:0]   mbx_out_data;
  logic          mbx_out_wr;
  logic          mbx_out_busy;
  logic [AW-1:0] loc_addr;
  logic [15:0]   loc_rdata;
  logic          host_oe;
  logic [15:0]   host_dat;
  logic [15:0]   rv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign otg_data = host_oe ? host_dat : 16'hzzzz;
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (otg_data[gi]);
  end

  hpi_slave_port #(.MEM_AW(AW)) dut (
    .Clk          (clk),
    .Reset_N      (rst_n),
    .OTG_ADDR     (otg_addr),
    .OTG_RD_N     (rd_n),
    .OTG_WR_N     (wr_n),
    .OTG_CS_N     (cs_n),
    .OTG_DATA     (otg_data),
    .OTG_INT      (otg_int),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_busy (mbx_out_busy),
    .loc_addr     (loc_addr),
    .loc_rdata    (loc_rdata)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    otg_addr = a; host_dat = d; host_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (6) @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(negedge clk);
    host_oe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    otg_addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (6) @(negedge clk);
    d = otg_data;
    repeat (2) @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic out_wr(input logic [15:0] d);
    @(negedge clk);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge clk);
    mbx_out_wr = 1'b0;
  endtask

  task automatic loc_rd(input logic [AW-1:0] a, output logic [15:0] d);
    @(negedge clk);
    loc_addr = a;
    repeat (2) @(negedge clk);
    d = loc_rdata;
  endtask

  initial begin
    rst_n = 1'b0; otg_addr = 2'b00; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
    mbx_in_ack = 1'b0; mbx_out_data = 16'h0000; mbx_out_wr = 1'b0;
    loc_addr = '0; host_oe = 1'b0; host_dat = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_bus_z", otg_data, 16'hFFFF);
    chk("rst_int", {15'b0, otg_int}, 16'h0000);
    chk("rst_busy", {15'b0, mbx_out_busy}, 16'h0000);
    chk("rst_in_vld", {15'b0, mbx_in_valid}, 16'h0000);
    chk("rst_in_data", mbx_in_data, 16'h0000);
    chk("rst_loc_rdata", loc_rdata, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // pointer auto-increment through the DATA window
    host_wr(A_ADDR, 16'h0010);
    host_wr(A_DATA, 16'hBEEF);
    host_wr(A_DATA, 16'h1234);
    host_wr(A_ADDR, 16'h0010);
    host_rd(A_DATA, rv); chk("data_rd0", rv, 16'hBEEF);
    host_rd(A_DATA, rv); chk("data_rd1", rv, 16'h1234);
    host_rd(A_ADDR, rv); chk("ptr_after", rv, 16'h0014);
    loc_rd(7'h08, rv); chk("loc_rd8", rv, 16'hBEEF);
    loc_rd(7'h09, rv); chk("loc_rd9", rv, 16'h1234);

    // inbound mailbox, overrun, write-1-to-clear
    host_wr(A_MBX, 16'hA5A5);
    chk("in_vld", {15'b0, mbx_in_valid}, 16'h0001);
    chk("in_data", mbx_in_data, 16'hA5A5);
    host_rd(A_STS, rv); chk("sts_in_vld", rv, 16'h0002);
    host_wr(A_MBX, 16'h5A5A);
    chk("in_data2", mbx_in_data, 16'h5A5A);
    host_rd(A_STS, rv); chk("sts_overrun", rv, 16'h0006);
    host_wr(A_STS, 16'h0004);
    host_rd(A_STS, rv); chk("sts_w1c", rv, 16'h0002);
    @(negedge clk); mbx_in_ack = 1'b1;
    @(negedge clk); mbx_in_ack = 1'b0;
    chk("in_vld_ack", {15'b0, mbx_in_valid}, 16'h0000);
    host_rd(A_STS, rv); chk("sts_acked", rv, 16'h0000);

    // outbound mailbox and host interrupt
    out_wr(16'h1357);
    chk("int_set", {15'b0, otg_int}, 16'h0001);
    chk("busy_set", {15'b0, mbx_out_busy}, 16'h0001);
    out_wr(16'h2468);
    host_rd(A_STS, rv); chk("sts_full", rv, 16'h0001);
    host_rd(A_MBX, rv); chk("mbx_out_rd", rv, 16'h1357);
    chk("int_clr", {15'b0, otg_int}, 16'h0000);
    chk("busy_clr", {15'b0, mbx_out_busy}, 16'h0000);
    out_wr(16'h0F0F);
    host_rd(A_MBX, rv); chk("mbx_out_rd2", rv, 16'h0F0F);

    // pointer wrap and aliasing into the top RAM word
    host_wr(A_ADDR, 16'hFFFE);
    host_wr(A_DATA, 16'h00FF);
    host_rd(A_ADDR, rv); chk("ptr_wrap", rv, 16'h0000);
    loc_rd(7'h7F, rv); chk("loc_rd7f", rv, 16'h00FF);

    // read and write strobes together: protocol error, no side effects
    host_wr(A_ADDR, 16'h0020);
    host_wr(A_DATA, 16'h7777);
    host_wr(A_ADDR, 16'h0020);
    @(negedge clk);
    otg_addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("err_bus_z", otg_data, 16'hFFFF);
    rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
    repeat (8) @(negedge clk);
    loc_rd(7'h10, rv); chk("err_ram_kept", rv, 16'h7777);
    host_rd(A_ADDR, rv); chk("err_ptr_kept", rv, 16'h0020);
    host_rd(A_STS, rv); chk("sts_perr", rv, 16'h0008);
    host_wr(A_STS, 16'h0008);
    host_rd(A_STS, rv); chk("sts_perr_clr", rv, 16'h0000);

    // reset asserted while the bus is being driven
    out_wr(16'hCAFE);
    host_wr(A_MBX, 16'h1111);
    @(negedge clk);
    otg_addr = A_ADDR; cs_n = 1'b0; rd_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_drive", otg_data, 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_z", otg_data, 16'hFFFF);
    chk("mid_rst_int", {15'b0, otg_int}, 16'h0000);
    chk("mid_rst_busy", {15'b0, mbx_out_busy}, 16'h0000);
    chk("mid_rst_in_vld", {15'b0, mbx_in_valid}, 16'h0000);
    chk("mid_rst_in_data", mbx_in_data, 16'h0000);
    chk("mid_rst_loc", loc_rdata, 16'h0000);
    @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    host_rd(A_ADDR, rv); chk("post_rst_ptr", rv, 16'h0000);
    host_rd(A_STS, rv); chk("post_rst_sts", rv, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
